// File: rtl/ddr3_port_arbiter_if.sv
// Bundle between the SoC requesters, the DDR3 port arbiter and the DDR3 controller app interface.
// The master modport is the arbiter's view; slave is the requesters plus controller side.
interface ddr3_port_arbiter_if #(
    parameter int NPORT = 3,
    parameter int AW    = 29,
    parameter int DW    = 128
);
    // Requester side
    logic [NPORT-1:0]        req;
    logic [NPORT-1:0]        we;
    logic [NPORT*AW-1:0]     adr;
    logic [NPORT*DW-1:0]     dati;
    logic [NPORT*DW/8-1:0]   sel;
    logic [NPORT-1:0]        ack;
    logic [DW-1:0]           dato;
    logic                    busy;

    // Controller app side
    logic                    app_en;
    logic [2:0]              app_cmd;
    logic [AW-1:0]           app_addr;
    logic                    app_rdy;
    logic                    app_wdf_wren;
    logic                    app_wdf_end;
    logic [DW-1:0]           app_wdf_data;
    logic [DW/8-1:0]         app_wdf_mask;
    logic                    app_wdf_rdy;
    logic [DW-1:0]           app_rd_data;
    logic                    app_rd_data_valid;

    modport master (
        input  req, we, adr, dati, sel,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        output ack, dato, busy,
        output app_en, app_cmd, app_addr,
        output app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );

    modport slave (
        output req, we, adr, dati, sel,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
        input  ack, dato, busy,
        input  app_en, app_cmd, app_addr,
        input  app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask
    );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one DDR3 controller app interface among NPORT requesters.
// Optional macro DDR3_ARB_PRIO0_EN gives port 0 strict priority over the rotation.
module ddr3_port_arbiter #(
    parameter int NPORT = 3,
    parameter int AW    = 29,
    parameter int DW    = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    ddr3_port_arbiter_if.master  bus,
    output logic [2:0]           dbg_state
);

    localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int MW = DW / 8;

    // Handshakes: a controller transfer happens in a cycle where our valid (app_en or
    // app_wdf_wren) and the controller's ready (app_rdy or app_wdf_rdy) are both high;
    // valid and its payload stay stable until then. req is held until ack, ack is one cycle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_CMD    = 3'd2,
        S_RDWAIT = 3'd3,
        S_ACK    = 3'd4
    } state_t;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      gnt_q;
    logic               we_q;
    logic [AW-1:0]      adr_q;
    logic [DW-1:0]      dat_q;
    logic [MW-1:0]      mask_q;
    logic [NPORT-1:0]   ack_q;
    logic [DW-1:0]      dato_q;
    logic               en_q;
    logic [2:0]         cmd_q;
    logic               wren_q;

    logic [IW-1:0]      pick;
    logic               pick_vld;
    logic [IW:0]        sum;
    logic [IW-1:0]      idx;
    logic [NPORT-1:0]   gnt_onehot;

    // Scan downward so the requester closest above the pointer is the last one to win.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IW + 1)'(i);
            if (sum >= (IW + 1)'(NPORT)) sum = sum - (IW + 1)'(NPORT);
            idx = sum[IW-1:0];
            if (bus.req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
`ifdef DDR3_ARB_PRIO0_EN
        if (bus.req[0]) begin
            pick     = '0;
            pick_vld = 1'b1;
        end
`endif
    end

    assign gnt_onehot = NPORT'(1) << gnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            ptr    <= '0;
            gnt_q  <= '0;
            we_q   <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            mask_q <= '0;
            ack_q  <= '0;
            dato_q <= '0;
            en_q   <= 1'b0;
            cmd_q  <= 3'b000;
            wren_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        gnt_q  <= pick;
                        we_q   <= bus.we[pick];
                        adr_q  <= bus.adr[int'(pick)*AW +: AW];
                        dat_q  <= bus.dati[int'(pick)*DW +: DW];
                        mask_q <= ~bus.sel[int'(pick)*MW +: MW];
                        if (bus.we[pick]) begin
                            cmd_q  <= 3'b000;
                            wren_q <= 1'b1;
                            state  <= S_WDATA;
                        end else begin
                            cmd_q  <= 3'b001;
                            en_q   <= 1'b1;
                            state  <= S_CMD;
                        end
                    end
                end
                S_WDATA: begin
                    // Write data goes first so the command never waits on a missing beat.
                    if (bus.app_wdf_rdy) begin
                        wren_q <= 1'b0;
                        en_q   <= 1'b1;
                        state  <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (bus.app_rdy) begin
                        en_q <= 1'b0;
                        if (we_q) begin
                            ack_q <= gnt_onehot;
                            state <= S_ACK;
                        end else begin
                            state <= S_RDWAIT;
                        end
                    end
                end
                S_RDWAIT: begin
                    if (bus.app_rd_data_valid) begin
                        dato_q <= bus.app_rd_data;
                        ack_q  <= gnt_onehot;
                        state  <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q <= '0;
                    state <= S_IDLE;
`ifdef DDR3_ARB_PRIO0_EN
                    if (gnt_q != '0)
                        ptr <= (gnt_q == IW'(NPORT - 1)) ? '0 : gnt_q + 1'b1;
`else
                    ptr <= (gnt_q == IW'(NPORT - 1)) ? '0 : gnt_q + 1'b1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack          = ack_q;
    assign bus.dato         = dato_q;
    assign bus.busy         = (state != S_IDLE);
    assign bus.app_en       = en_q;
    assign bus.app_cmd      = cmd_q;
    assign bus.app_addr     = adr_q;
    assign bus.app_wdf_wren = wren_q;
    assign bus.app_wdf_end  = wren_q;
    assign bus.app_wdf_data = dat_q;
    assign bus.app_wdf_mask = mask_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed bench for ddr3_port_arbiter: read, write with backpressure, rotation,
// command stall and reset during a read; ack order is tracked by an expected queue.
module tb_ddr3_port_arbiter;
  localparam int NPORT = 3;
  localparam int AW    = 29;
  localparam int DW    = 128;
  localparam int MW    = DW / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] exp_q[$];

  ddr3_port_arbiter_if #(.NPORT(NPORT), .AW(AW), .DW(DW)) bus();

  ddr3_port_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] s);
    bus.we[p]            = w;
    bus.adr[p*AW +: AW]  = a;
    bus.dati[p*DW +: DW] = d;
    bus.sel[p*MW +: MW]  = s;
  endtask

  // scoreboard: every ack must be one-hot and match the next expected port
  always @(negedge clk) begin : ack_mon
    logic [7:0] p;
    if (!rst && bus.ack != '0) begin
      check("ack_onehot", DW'($countones(bus.ack)), DW'(1));
      if (exp_q.size() == 0) begin
        check("ack_unexpected", DW'(bus.ack), DW'(0));
      end else begin
        p = exp_q.pop_front();
        check("ack_port", DW'(bus.ack), DW'(3'b001 << p));
      end
    end
  end

  localparam logic [DW-1:0] RD1 = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
  localparam logic [DW-1:0] RD2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [DW-1:0] WD2 = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;

  int got;

  initial begin
    bus.req = '0;
    bus.we = '0;
    bus.adr = '0;
    bus.dati = '0;
    bus.sel = '0;
    bus.app_rdy = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    bus.app_rd_data = '0;
    bus.app_rd_data_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", DW'(bus.ack), DW'(0));
    check("rst_en_wren", DW'({bus.app_en, bus.app_wdf_wren, bus.app_wdf_end, bus.busy}), DW'(0));
    check("rst_dato", bus.dato, '0);
    check("rst_cmd_addr_mask", DW'({bus.app_cmd, bus.app_addr, bus.app_wdf_mask}), DW'(0));
    rst = 1'b0;

    // port 1 read, immediate rdy and return
    bus.app_rdy = 1'b1;
    bus.app_rd_data = RD1;
    bus.app_rd_data_valid = 1'b1;
    set_port(1, 1'b0, 29'h0000100, '0, '0);
    bus.req = 3'b010;
    exp_q.push_back(8'd1);
    tick();
    check("rd_cmd", DW'({bus.app_en, bus.app_cmd, bus.app_addr}), DW'({1'b1, 3'b001, 29'h0000100}));
    check("rd_busy_noack", DW'({bus.busy, bus.ack}), DW'({1'b1, 3'b000}));
    tick();
    check("rd_wait", DW'({bus.app_en, bus.ack}), DW'(0));
    tick();
    check("rd_ack", DW'(bus.ack), DW'(3'b010));
    check("rd_dato", bus.dato, RD1);
    bus.req = '0;
    tick();
    check("rd_done", DW'({bus.ack, bus.busy}), DW'(0));

    // port 2 write, wdf_rdy low for 3 cycles
    bus.app_rd_data_valid = 1'b0;
    bus.app_wdf_rdy = 1'b0;
    set_port(2, 1'b1, 29'h0000200, WD2, 16'h00FF);
    bus.req = 3'b100;
    exp_q.push_back(8'd2);
    tick();
    check("wr_data", bus.app_wdf_data, WD2);
    check("wr_mask", DW'(bus.app_wdf_mask), DW'(16'hFF00));
    for (int i = 0; i < 3; i++) begin
      check("wr_hold", DW'({bus.app_wdf_wren, bus.app_wdf_end, bus.app_en}), DW'(3'b110));
      tick();
    end
    bus.app_wdf_rdy = 1'b1;
    check("wr_hold_last", DW'({bus.app_wdf_wren, bus.app_en}), DW'(2'b10));
    tick();
    bus.app_wdf_rdy = 1'b0;
    check("wr_cmd", DW'({bus.app_wdf_wren, bus.app_en, bus.app_cmd, bus.app_addr}),
          DW'({1'b0, 1'b1, 3'b000, 29'h0000200}));
    tick();
    check("wr_ack", DW'({bus.ack, bus.app_en}), DW'({3'b100, 1'b0}));
    check("wr_dato_kept", bus.dato, RD1);
    bus.req = '0;
    tick();
    check("wr_ack_one", DW'(bus.ack), DW'(0));

    // all three ports read continuously
    bus.app_rd_data = RD2;
    bus.app_rd_data_valid = 1'b1;
    set_port(0, 1'b0, 29'h0000040, '0, '0);
    set_port(1, 1'b0, 29'h0000140, '0, '0);
    set_port(2, 1'b0, 29'h0000240, '0, '0);
`ifdef DDR3_ARB_PRIO0_EN
    exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    exp_q.push_back(8'd2); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
`else
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd2);
`endif
    bus.req = 3'b111;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      tick();
      if (bus.ack != '0) begin
        got++;
`ifdef DDR3_ARB_PRIO0_EN
        if (got == 2) bus.req[0] = 1'b0;
`endif
        if (got == 6) bus.req = '0;
      end
    end
    check("rr_count", DW'(got), DW'(6));
    tick();
    tick();
    check("rr_idle", DW'({bus.busy, bus.ack}), DW'(0));

    // command stalled 10 cycles
    bus.app_rdy = 1'b0;
    set_port(1, 1'b0, 29'h0000155, '0, '0);
    bus.req = 3'b010;
    exp_q.push_back(8'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("cmd_stall", DW'({bus.app_en, bus.app_addr, bus.busy, bus.ack}),
            DW'({1'b1, 29'h0000155, 1'b1, 3'b000}));
      tick();
    end
    bus.app_rdy = 1'b1;
    tick();
    check("stall_rdwait", DW'({bus.app_en, bus.ack}), DW'(0));
    tick();
    check("stall_ack", DW'(bus.ack), DW'(3'b010));
    bus.req = '0;
    tick();

    // reset while waiting for read data
    bus.app_rd_data_valid = 1'b0;
    set_port(2, 1'b0, 29'h0000260, '0, '0);
    bus.req = 3'b100;
    exp_q.push_back(8'd2);
    tick();
    tick();
    check("pre_rst_state", DW'(dbg_state), DW'(3));
    #2 rst = 1'b1;
    #1;
    check("async_rst_out", DW'({bus.app_en, bus.app_wdf_wren, bus.busy, bus.ack, bus.app_addr}), DW'(0));
    check("async_rst_dato", bus.dato, '0);
    exp_q.delete();
    bus.req = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.app_rd_data = RD1;
    bus.app_rd_data_valid = 1'b1;
    tick();
    tick();
    check("late_valid_ignored", DW'({dbg_state, bus.busy, bus.ack}), DW'(0));
    check("late_valid_dato", bus.dato, '0);
    bus.req = 3'b111;
    exp_q.push_back(8'd0);
    tick();
    check("post_rst_grant", DW'(bus.app_addr), DW'(29'h0000040));
    tick();
    bus.req = 3'b110;
    tick();
    check("post_rst_ack", DW'(bus.ack), DW'(3'b001));
    check("post_rst_dato", bus.dato, RD1);
    bus.req = '0;
    tick();
    tick();
    tick();
    tick();
    tick();

    check("exp_q_empty", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // hard stop in case the sequence above stalls on a clock wait
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
